// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC sequencer + imem req/ack fetcher feeding a DEPTH-entry {pc,instr} queue to decode;
// ack -> id_valid one cycle later, id_ready=0 fills the queue then stalls fetch. IF_BYPASS_EN: empty-queue acks forwarded same cycle.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   hold_addr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic empty;
    logic full;
    logic ack_take;
    logic push;
    logic pop_fifo;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Once a request is out it must be held until ack, even across a redirect.
    always_comb begin
        imem_req = 1'b0;
        if (!rst) begin
            if (state == IDLE)
                imem_req = !full && !redirect;
            else
                imem_req = 1'b1;
        end
    end

    assign imem_addr = (state == IDLE) ? fetch_pc : hold_addr;

    // A word is kept only if it belongs to the current fetch stream.
    assign ack_take = imem_req && imem_ack && !redirect && (state != DROP);
    assign pop_fifo = !empty && id_ready;

`ifdef IF_BYPASS_EN
    logic bypass;
    assign bypass   = ack_take && empty;
    assign push     = ack_take && !(bypass && id_ready);
    assign id_valid = !empty || bypass;
    assign id_instr = bypass ? imem_rdata : instr_q[rd_ptr];
    assign id_pc    = bypass ? imem_addr  : pc_q[rd_ptr];
`else
    assign push     = ack_take;
    assign id_valid = !empty;
    assign id_instr = instr_q[rd_ptr];
    assign id_pc    = pc_q[rd_ptr];
`endif

    assign op    = id_instr[31:26];
    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign rd    = id_instr[15:11];
    assign shamt = id_instr[10:6];
    assign func  = id_instr[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req && !imem_ack) begin
                        state     <= WAIT;
                        hold_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (imem_ack)
                        state <= IDLE;
                    else if (redirect)
                        state <= DROP;
                end
                DROP: begin
                    if (imem_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (redirect)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (ack_take)
                fetch_pc <= fetch_pc + 32'd4;

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_fifo)
                    rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop_fifo})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= imem_addr;
            instr_q[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: imem responder with variable ack delay and an in-order PC stream model.
module tb_if_fetch_queue;

`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic        redirect;
    logic [31:0] redirect_pc;

    if_fetch_queue dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int          mem_min = 0, mem_max = 0, mem_cnt = 0;
    bit          mem_busy = 0;
    logic [31:0] mem_addr = 0;

    logic        drv_redirect = 0, drv_ready = 0;
    logic [31:0] drv_rpc = 0;

    logic        o_req, o_ack, o_newreq, o_busy, o_valid, o_pop;
    logic [31:0] o_addr, o_pc, o_instr, o_fields;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0005;
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // One clock cycle: drive inputs, answer imem like a slave with random latency, capture outputs.
    task automatic step();
        @(negedge clk);
        redirect    = drv_redirect;
        redirect_pc = drv_rpc;
        id_ready    = drv_ready;
        imem_ack    = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        o_req = imem_req; o_addr = imem_addr; o_newreq = 1'b0; o_ack = 1'b0; o_busy = mem_busy;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = int'($urandom_range(mem_max, mem_min));
                mem_addr = imem_addr;
                o_newreq = 1'b1;
            end
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memfn(imem_addr);
                mem_busy   = 1'b0;
                o_ack      = 1'b1;
            end else begin
                mem_cnt--;
            end
        end
        #1;
        o_valid  = id_valid;
        o_pop    = id_valid && id_ready;
        o_pc     = id_pc;
        o_instr  = id_instr;
        o_fields = {op, rs, rt, rd, shamt, func};
        @(posedge clk);
    endtask

    task automatic do_reset();
        drv_redirect = 0; drv_rpc = 0; drv_ready = 0;
        redirect = 0; redirect_pc = 0; id_ready = 0; imem_ack = 0; imem_rdata = 0;
        mem_busy = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        redirect = 0; redirect_pc = 0; id_ready = 0; imem_ack = 0; imem_rdata = 0;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passes++;
        checks++; if (imem_addr !== 32'h3000) $display("FAIL reset_addr: got %h want 00003000", imem_addr); else passes++;
        checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", id_valid); else passes++;
        do_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_req, exp_pop;
        int pops;
        do_reset();
        mem_min = 0; mem_max = 0; drv_ready = 1;
        exp_req = 32'h3000; exp_pop = 32'h3000; pops = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) begin
                checks++; if (o_valid !== BYP) $display("FAIL seq_first_valid: got %b want %b", o_valid, BYP); else passes++;
            end
            checks++; if (!o_newreq || o_addr !== exp_req) $display("FAIL seq_req_addr: got %h req=%b want %h", o_addr, o_newreq, exp_req); else passes++;
            exp_req += 4;
            if (o_pop) begin
                checks++; if (o_pc !== exp_pop || o_fields !== memfn(exp_pop)) $display("FAIL seq_pop: got pc %h fields %h want %h %h", o_pc, o_fields, exp_pop, memfn(exp_pop)); else passes++;
                exp_pop += 4; pops++;
            end
        end
        checks++; if (pops != (BYP ? 8 : 7)) $display("FAIL seq_pop_count: got %0d want %0d", pops, BYP ? 8 : 7); else passes++;
    endtask

    task automatic test_stall();
        int acks;
        logic [31:0] exp_pop, first_new;
        bit got_new;
        do_reset();
        mem_min = 0; mem_max = 0; drv_ready = 0; acks = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_ack) acks++;
        end
        checks++; if (acks != 4) $display("FAIL stall_push_count: got %0d want 4", acks); else passes++;
        checks++; if (o_req !== 1'b0) $display("FAIL stall_req_drop: got %b want 0", o_req); else passes++;
        drv_ready = 1; exp_pop = 32'h3000; got_new = 0; first_new = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_newreq && !got_new) begin got_new = 1; first_new = o_addr; end
            if (o_pop) begin
                checks++; if (o_pc !== exp_pop) $display("FAIL stall_pop_order: got %h want %h", o_pc, exp_pop); else passes++;
                exp_pop += 4;
            end
        end
        checks++; if (!got_new || first_new !== 32'h3010) $display("FAIL stall_resume_addr: got %h seen=%b want 00003010", first_new, got_new); else passes++;
    endtask

    task automatic test_redirect_drop();
        bit got_pop, got_new;
        do_reset();
        mem_min = 3; mem_max = 3; drv_ready = 0;
        step();
        drv_redirect = 1; drv_rpc = 32'h4000;
        step();
        drv_redirect = 0;
        for (int c = 0; c < 3; c++) begin
            if (c < 2 || !o_ack) step();
            checks++; if (!o_req || o_addr !== 32'h3000) $display("FAIL drop_stale_hold: got req=%b addr %h want 1 00003000", o_req, o_addr); else passes++;
        end
        drv_ready = 1; got_pop = 0; got_new = 0;
        for (int c = 0; c < 40 && !got_pop; c++) begin
            step();
            if (o_newreq && !got_new) begin
                got_new = 1;
                checks++; if (o_addr !== 32'h4000) $display("FAIL drop_next_req: got %h want 00004000", o_addr); else passes++;
            end
            if (o_pop) begin
                got_pop = 1;
                checks++; if (o_pc !== 32'h4000 || o_instr !== memfn(32'h4000)) $display("FAIL drop_first_pc: got %h %h want 00004000 %h", o_pc, o_instr, memfn(32'h4000)); else passes++;
            end
        end
        if (!got_pop) begin checks++; $display("FAIL drop_timeout: got no pop want pop of 00004000"); end
    endtask

    task automatic test_redirect_ack();
        bit got_pop;
        do_reset();
        mem_min = 1; mem_max = 1; drv_ready = 0;
        repeat (3) step();
        drv_redirect = 1; drv_rpc = 32'h5002;
        step();
        drv_redirect = 0;
        checks++; if (o_ack !== 1'b1 || o_addr !== 32'h3004) $display("FAIL redir_ack_setup: got ack=%b addr %h want 1 00003004", o_ack, o_addr); else passes++;
        step();
        checks++; if (o_valid !== 1'b0) $display("FAIL redir_ack_valid: got %b want 0", o_valid); else passes++;
        checks++; if (!o_newreq || o_addr !== 32'h5000) $display("FAIL redir_ack_next_req: got %h new=%b want 00005000", o_addr, o_newreq); else passes++;
        drv_ready = 1; got_pop = 0;
        for (int c = 0; c < 20 && !got_pop; c++) begin
            step();
            if (o_pop) begin
                got_pop = 1;
                checks++; if (o_pc !== 32'h5000) $display("FAIL redir_ack_first_pc: got %h want 00005000", o_pc); else passes++;
            end
        end
        if (!got_pop) begin checks++; $display("FAIL redir_ack_timeout: got no pop want pop"); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_list [3];
        logic [31:0] reqs [$];
        int npop;
        exp_list[0] = 32'hFFFF_FFFC; exp_list[1] = 32'h0000_0000; exp_list[2] = 32'h0000_0004;
        do_reset();
        mem_min = 0; mem_max = 2; drv_ready = 1;
        repeat (3) step();
        drv_redirect = 1; drv_rpc = 32'hFFFF_FFFF;
        step();
        drv_redirect = 0; npop = 0;
        for (int c = 0; c < 60 && npop < 3; c++) begin
            step();
            if (o_newreq) reqs.push_back(o_addr);
            if (o_pop) begin
                checks++; if (o_pc !== exp_list[npop] || o_instr !== memfn(exp_list[npop])) $display("FAIL wrap_pop%0d: got %h want %h", npop, o_pc, exp_list[npop]); else passes++;
                npop++;
            end
        end
        checks++; if (npop != 3) $display("FAIL wrap_timeout: got %0d pops want 3", npop); else passes++;
        checks++; if (reqs.size() < 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) $display("FAIL wrap_req_addrs: got %0d reqs want fffffffc,00000000", reqs.size()); else passes++;
    endtask

    task automatic test_reset_midwait();
        bit got_pop, got_new;
        do_reset();
        mem_min = 0; mem_max = 0; drv_ready = 0;
        repeat (2) step();
        mem_min = 3; mem_max = 3;
        step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL midrst_req: got %b want 0", imem_req); else passes++;
        checks++; if (imem_addr !== 32'h3000) $display("FAIL midrst_addr: got %h want 00003000", imem_addr); else passes++;
        checks++; if (id_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", id_valid); else passes++;
        @(posedge clk);
        #1 rst = 1'b0;
        mem_busy = 0; mem_min = 0; mem_max = 0; drv_ready = 1; got_pop = 0; got_new = 0;
        for (int c = 0; c < 10 && !got_pop; c++) begin
            step();
            if (o_newreq && !got_new) begin
                got_new = 1;
                checks++; if (o_addr !== 32'h3000) $display("FAIL midrst_refetch: got %h want 00003000", o_addr); else passes++;
            end
            if (o_pop) begin
                got_pop = 1;
                checks++; if (o_pc !== 32'h3000) $display("FAIL midrst_first_pc: got %h want 00003000", o_pc); else passes++;
            end
        end
        if (!got_pop) begin checks++; $display("FAIL midrst_timeout: got no pop want pop"); end
    endtask

`ifdef IF_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        mem_min = 0; mem_max = 0; drv_ready = 1;
        step();
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h3000) $display("FAIL byp_same_cycle: got v=%b pc %h want 1 00003000", o_valid, o_pc); else passes++;
        mem_min = 2; mem_max = 2;
        step();
        checks++; if (o_valid !== 1'b0) $display("FAIL byp_no_push: got %b want 0", o_valid); else passes++;
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc, exp_i;
        bit prev_redir;
        int pops;
        do_reset();
        mem_min = 0; mem_max = 3;
        exp_pc = 32'h3000; prev_redir = 0; pops = 0;
        for (int c = 0; c < 2000; c++) begin
            drv_ready    = ($urandom_range(9, 0) < 7);
            drv_redirect = ($urandom_range(99, 0) < 4);
            drv_rpc      = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            step();
            if (o_busy) begin
                checks++; if (!o_req || o_addr !== mem_addr) $display("FAIL rnd_req_hold: got req=%b addr %h want 1 %h", o_req, o_addr, mem_addr); else passes++;
            end
            if (prev_redir && !(BYP && o_ack)) begin
                checks++; if (o_valid !== 1'b0) $display("FAIL rnd_valid_after_redirect: got %b want 0", o_valid); else passes++;
            end
            if (o_pop) begin
                exp_i = memfn(exp_pc);
                checks++; if (o_pc !== exp_pc) $display("FAIL rnd_pc: got %h want %h", o_pc, exp_pc); else passes++;
                checks++; if (o_fields !== exp_i || o_instr !== exp_i) $display("FAIL rnd_instr: got %h fields %h want %h", o_instr, o_fields, exp_i); else passes++;
                exp_pc += 4; pops++;
            end
            if (drv_redirect) exp_pc = {drv_rpc[31:2], 2'b00};
            prev_redir = drv_redirect;
        end
        drv_redirect = 0;
        checks++; if (pops < 200) $display("FAIL rnd_throughput: got %0d pops want >=200", pops); else passes++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_midwait();
`ifdef IF_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
